memoria_cache_assoc: RTL and testbench
======================================

// Module: memoria_cache_assoc
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate cache sitting
//  between the CPU request port and a slow backing memory. Successor of the fixed
//  2-way/4-set/3-bit cache: adds width/depth/way parameters, valid/ready request
//  handshake, a real memory-side interface with variable latency, and true-LRU for 4 ways.
// PARAMETERS
//  DATA_W   3  word width (one word per line)
//  ADDR_W   5  CPU/memory address width; tag = ADDR_W-INDEX_W bits
//  INDEX_W  2  set index width (2**INDEX_W sets, address[INDEX_W-1:0])
//  WAYS     2  associativity, legal values 2 or 4
// PORTS
//  clock        in   1        rising-edge clock
//  resetn       in   1        asynchronous active-low reset
//  req_valid    in   1        CPU request present
//  req_ready    out  1        cache can accept (high only in IDLE)
//  wren         in   1        1 = write `data`, 0 = read
//  data         in   DATA_W   write data
//  address      in   ADDR_W   word address {tag,index}
//  resp_valid   out  1        one-cycle response strobe
//  hit          out  1        request hit on first lookup
//  valid        out  1        served line valid (always 1 with resp_valid)
//  dirty        out  1        served line dirty after the access
//  writeBack    out  1        this request evicted a dirty line
//  tag          out  ADDR_W-INDEX_W  tag of served line
//  dadoParaCPU  out  DATA_W   read data (write: the written value)
//  mem_req      out  1        memory request, held until mem_ack
//  mem_we       out  1        1 = write-back, 0 = refill
//  mem_addr     out  ADDR_W   memory word address
//  mem_wdata    out  DATA_W   write-back data
//  mem_ack      in   1        memory done (one cycle); mem_rdata valid with it
//  mem_rdata    in   DATA_W   refill data
// BEHAVIOUR
//  - Reset (async): FSM->IDLE; all valid/dirty bits 0; LRU age of way w = w;
//    every output 0 except req_ready=1. Data/tag arrays not reset.
//  - FSM: IDLE -> LOOKUP -> {RESP | WRITEBACK | REFILL}; WRITEBACK -> REFILL;
//    REFILL -> LOOKUP; RESP -> IDLE.
//  - IDLE: req_valid&req_ready latches wren/data/address; inputs ignored thereafter.
//  - LOOKUP: hit = any way valid with matching tag. Hit: read or write word,
//    write sets dirty=1, update LRU, go RESP. Miss: victim = lowest-index invalid
//    way, else way with max age; dirty victim -> WRITEBACK, else REFILL.
//  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim
//    word; on mem_ack set writeBack flag, clear victim valid, go REFILL.
//  - REFILL: mem_req=1, mem_we=0, mem_addr=latched address; on mem_ack write word,
//    tag, valid=1, dirty=0 into victim; back to LOOKUP (now hits; hit flag stays 0).
//  - RESP: resp_valid=1 for exactly one cycle with hit/valid/dirty/writeBack/tag/
//    dadoParaCPU; outputs hold until next RESP. Hit latency: resp 2 cycles after accept.
//  - LRU: on access, accessed way age->0; ways with age < its old age increment.
//    Ages always a permutation of 0..WAYS-1.
//  - mem_ack outside WRITEBACK/REFILL ignored. Reset mid-miss: mem_req drops
//    immediately, transaction abandoned, no response.
// CONFIGURATION
//  MEMORIA_CACHE_STATS_EN defined: extra outputs hit_count[15:0], miss_count[15:0],
//  wb_count[15:0]; increment in RESP per hit/miss/writeBack; saturate at 16'hFFFF;
//  reset 0. Undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  1 reset; read 5'b10000, mem_rdata=3 -> one refill mem_addr=16; resp hit=0
//    writeBack=0 tag=3'b100 dadoParaCPU=3.
//  2 read 5'b10000 again -> no mem_req, resp_valid exactly 2 cycles after
//    accept, hit=1 dadoParaCPU=3.
//  3 write 5 to 5'b00001 (refill rdata=0) -> hit=0 dirty=1; read 5'b00001 ->
//    hit=1 dadoParaCPU=5.
//  4 write 4 to 5'b01001, then read 5'b00101 -> WRITEBACK mem_addr=1 wdata=5,
//    then REFILL mem_addr=5; resp writeBack=1 tag=3'b001 dirty=0.
//  5 assert resetn low while mem_req high in REFILL -> mem_req=0 same
//    cycle; after release req_ready=1, read 5'b10000 misses.
//  6 with MEMORIA_CACHE_STATS_EN, after scenarios 1-4 -> hit_count=2,
//    miss_count=4, wb_count=1; WAYS=4 bench: 5 tags one set evict oldest.

Source files
------------

// File: rtl/memoria_cache_assoc_if.sv
// CPU request/response and backing-memory signal bundle for memoria_cache_assoc.
// slave = cache side, master = CPU plus backing memory.
interface memoria_cache_assoc_if #(
    parameter int DATA_W  = 3,
    parameter int ADDR_W  = 5,
    parameter int INDEX_W = 2
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    logic              req_valid;
    logic              req_ready;
    logic              wren;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] address;

    logic              resp_valid;
    logic              hit;
    logic              valid;
    logic              dirty;
    logic              writeBack;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] dadoParaCPU;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, wren, data, address, mem_ack, mem_rdata,
        output req_ready, resp_valid, hit, valid, dirty, writeBack, tag, dadoParaCPU,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, wren, data, address, mem_ack, mem_rdata,
        input  req_ready, resp_valid, hit, valid, dirty, writeBack, tag, dadoParaCPU,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memoria_cache_assoc.sv
// N-way set-associative write-back/write-allocate cache with true-LRU and a
// variable-latency memory port. Optional counters: define MEMORIA_CACHE_STATS_EN.
//
// state     | meaning
// IDLE      | waiting for a CPU request, req_ready high
// LOOKUP    | tag compare on the latched request
// WRITEBACK | dirty victim being written to memory
// REFILL    | victim way being loaded from memory
// RESP      | one-cycle response strobe
module memoria_cache_assoc #(
    parameter int DATA_W  = 3,
    parameter int ADDR_W  = 5,
    parameter int INDEX_W = 2,
    parameter int WAYS    = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    memoria_cache_assoc_if.slave bus
`ifdef MEMORIA_CACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count,
    output logic [15:0]          wb_count
`endif
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int WAY_W = (WAYS > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic              wren_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WAY_W-1:0]  victim_q;
    logic              wb_flag_q;
    logic              first_q;

    logic              hit_o_q;
    logic              valid_o_q;
    logic              dirty_o_q;
    logic              wb_o_q;
    logic [TAG_W-1:0]  tag_o_q;
    logic [DATA_W-1:0] rdata_o_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem [SETS][WAYS];
    logic [DATA_W-1:0] data_mem[SETS][WAYS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   rtag;
    logic               hit_any;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_any;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   old_way;
    logic [WAY_W-1:0]   victim_sel;
    logic               miss_dirty;

    assign idx  = addr_q[INDEX_W-1:0];
    assign rtag = addr_q[ADDR_W-1:INDEX_W];

    // Victim is the lowest invalid way; only when the set is full does LRU decide.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        old_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == rtag) && !hit_any) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w] && !inv_any) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[idx][w] == WAY_W'(WAYS - 1)) begin
                old_way = WAY_W'(w);
            end
        end
        victim_sel = inv_any ? inv_way : old_way;
        miss_dirty = !inv_any && dirty_q[idx][old_way];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_any)         state_d = S_RESP;
                else if (miss_dirty) state_d = S_WRITEBACK;
                else                 state_d = S_REFILL;
            end
            S_WRITEBACK: begin
                if (bus.mem_ack) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (bus.mem_ack) state_d = S_LOOKUP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.resp_valid = (state_q == S_RESP);
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            S_WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {tag_mem[idx][victim_q], idx};
                bus.mem_wdata = data_mem[idx][victim_q];
            end
            S_REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.hit         = hit_o_q;
    assign bus.valid       = valid_o_q;
    assign bus.dirty       = dirty_o_q;
    assign bus.writeBack   = wb_o_q;
    assign bus.tag         = tag_o_q;
    assign bus.dadoParaCPU = rdata_o_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wren_q    <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            victim_q  <= '0;
            wb_flag_q <= 1'b0;
            first_q   <= 1'b0;
            hit_o_q   <= 1'b0;
            valid_o_q <= 1'b0;
            dirty_o_q <= 1'b0;
            wb_o_q    <= 1'b0;
            tag_o_q   <= '0;
            rdata_o_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        wren_q    <= bus.wren;
                        wdata_q   <= bus.data;
                        addr_q    <= bus.address;
                        first_q   <= 1'b1;
                        wb_flag_q <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (hit_any) begin
                        // hit reports only the first lookup; the post-refill lookup keeps it 0
                        hit_o_q   <= first_q;
                        valid_o_q <= 1'b1;
                        dirty_o_q <= wren_q | dirty_q[idx][hit_way];
                        wb_o_q    <= wb_flag_q;
                        tag_o_q   <= rtag;
                        rdata_o_q <= wren_q ? wdata_q : data_mem[idx][hit_way];
                        if (wren_q) dirty_q[idx][hit_way] <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                age_q[idx][w] <= '0;
                            end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
                                age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
                            end
                        end
                    end else begin
                        victim_q <= victim_sel;
                        first_q  <= 1'b0;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack) begin
                        wb_flag_q               <= 1'b1;
                        valid_q[idx][victim_q]  <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if ((state_q == S_LOOKUP) && hit_any && wren_q) begin
            data_mem[idx][hit_way] <= wdata_q;
        end
        if ((state_q == S_REFILL) && bus.mem_ack) begin
            data_mem[idx][victim_q] <= bus.mem_rdata;
            tag_mem[idx][victim_q]  <= rtag;
        end
    end

`ifdef MEMORIA_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic [15:0] wb_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else if (state_q == S_RESP) begin
            if (hit_o_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (wb_o_q && (wb_cnt_q != 16'hFFFF)) wb_cnt_q <= wb_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_memoria_cache_assoc.sv
// Self-checking bench: a 2-way and a 4-way cache share one CPU/memory driver,
// checked by directed vectors and random traffic against an MRU-ordered model.
module tb_memoria_cache_assoc;
    logic clk;
    logic resetn;
    bit   sel;

    logic       req_valid;
    logic       wren;
    logic [2:0] data;
    logic [4:0] address;
    logic       mem_ack;
    logic [2:0] mem_rdata;

    memoria_cache_assoc_if #(.DATA_W(3), .ADDR_W(5), .INDEX_W(2)) bus2 ();
    memoria_cache_assoc_if #(.DATA_W(3), .ADDR_W(5), .INDEX_W(2)) bus4 ();

    assign bus2.req_valid = req_valid & ~sel;
    assign bus4.req_valid = req_valid & sel;
    assign bus2.mem_ack   = mem_ack & ~sel;
    assign bus4.mem_ack   = mem_ack & sel;
    assign bus2.wren      = wren;
    assign bus4.wren      = wren;
    assign bus2.data      = data;
    assign bus4.data      = data;
    assign bus2.address   = address;
    assign bus4.address   = address;
    assign bus2.mem_rdata = mem_rdata;
    assign bus4.mem_rdata = mem_rdata;

`ifdef MEMORIA_CACHE_STATS_EN
    logic [15:0] hc2, mc2, wc2, hc4, mc4, wc4;
`endif

    memoria_cache_assoc #(.DATA_W(3), .ADDR_W(5), .INDEX_W(2), .WAYS(2)) dut2 (
        .clock (clk),
        .resetn(resetn),
        .bus   (bus2)
`ifdef MEMORIA_CACHE_STATS_EN
        ,
        .hit_count (hc2),
        .miss_count(mc2),
        .wb_count  (wc2)
`endif
    );

    memoria_cache_assoc #(.DATA_W(3), .ADDR_W(5), .INDEX_W(2), .WAYS(4)) dut4 (
        .clock (clk),
        .resetn(resetn),
        .bus   (bus4)
`ifdef MEMORIA_CACHE_STATS_EN
        ,
        .hit_count (hc4),
        .miss_count(mc4),
        .wb_count  (wc4)
`endif
    );

    logic       o_req_ready, o_resp_valid, o_hit, o_valid, o_dirty, o_wb, o_mem_req, o_mem_we;
    logic [2:0] o_tag, o_data, o_mem_wdata;
    logic [4:0] o_mem_addr;

    always_comb begin
        o_req_ready  = sel ? bus4.req_ready   : bus2.req_ready;
        o_resp_valid = sel ? bus4.resp_valid  : bus2.resp_valid;
        o_hit        = sel ? bus4.hit         : bus2.hit;
        o_valid      = sel ? bus4.valid       : bus2.valid;
        o_dirty      = sel ? bus4.dirty       : bus2.dirty;
        o_wb         = sel ? bus4.writeBack   : bus2.writeBack;
        o_tag        = sel ? bus4.tag         : bus2.tag;
        o_data       = sel ? bus4.dadoParaCPU : bus2.dadoParaCPU;
        o_mem_req    = sel ? bus4.mem_req     : bus2.mem_req;
        o_mem_we     = sel ? bus4.mem_we      : bus2.mem_we;
        o_mem_addr   = sel ? bus4.mem_addr    : bus2.mem_addr;
        o_mem_wdata  = sel ? bus4.mem_wdata   : bus2.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: per cache, per set, lines kept in recency order (index 0 = most recent).
    int m_cnt[2][4];
    int m_tag[2][4][4];
    int m_dat[2][4][4];
    bit m_dty[2][4][4];
    int m_mem[32];
    int backing[32];

    function automatic void model_reset();
        for (int s = 0; s < 2; s++)
            for (int st = 0; st < 4; st++) m_cnt[s][st] = 0;
    endfunction

    function automatic int mfind(int s, int st, int tg);
        for (int i = 0; i < m_cnt[s][st]; i++)
            if (m_tag[s][st][i] == tg) return i;
        return -1;
    endfunction

    function automatic void mfront(int s, int st, int p);
        int t, d;
        bit y;
        t = m_tag[s][st][p];
        d = m_dat[s][st][p];
        y = m_dty[s][st][p];
        for (int i = p; i > 0; i--) begin
            m_tag[s][st][i] = m_tag[s][st][i-1];
            m_dat[s][st][i] = m_dat[s][st][i-1];
            m_dty[s][st][i] = m_dty[s][st][i-1];
        end
        m_tag[s][st][0] = t;
        m_dat[s][st][0] = d;
        m_dty[s][st][0] = y;
    endfunction

    function automatic void minsert(int s, int st, int tg, int d);
        for (int i = m_cnt[s][st]; i > 0; i--) begin
            m_tag[s][st][i] = m_tag[s][st][i-1];
            m_dat[s][st][i] = m_dat[s][st][i-1];
            m_dty[s][st][i] = m_dty[s][st][i-1];
        end
        m_tag[s][st][0] = tg;
        m_dat[s][st][0] = d;
        m_dty[s][st][0] = 1'b0;
        m_cnt[s][st]++;
    endfunction

    task automatic do_req(input bit wr, input logic [2:0] d, input logic [4:0] a,
                          output bit r_hit, output bit r_wb, output bit r_dirty,
                          output int r_tag, output int r_data, output int r_maddr0,
                          output int r_nops);
        int  s, st, tg, pos, ways, lru, cyc, lat, nops;
        int  e_wba, e_wbd, e_dat;
        bit  e_hit, e_wb, e_dty, busy, done;
        s    = sel ? 1 : 0;
        ways = sel ? 4 : 2;
        st   = int'(a[1:0]);
        tg   = int'(a[4:2]);
        pos  = mfind(s, st, tg);
        e_hit = (pos >= 0);
        e_wb  = 1'b0;
        e_wba = 0;
        e_wbd = 0;
        if (e_hit) begin
            mfront(s, st, pos);
        end else begin
            if (m_cnt[s][st] == ways) begin
                lru = ways - 1;
                if (m_dty[s][st][lru]) begin
                    e_wb  = 1'b1;
                    e_wba = m_tag[s][st][lru] * 4 + st;
                    e_wbd = m_dat[s][st][lru];
                    m_mem[e_wba] = e_wbd;
                end
                m_cnt[s][st]--;
            end
            minsert(s, st, tg, m_mem[int'(a)]);
        end
        if (wr) begin
            m_dat[s][st][0] = int'(d);
            m_dty[s][st][0] = 1'b1;
        end
        e_dat = m_dat[s][st][0];
        e_dty = m_dty[s][st][0];

        @(negedge clk);
        mem_ack = 1'b0;
        chk("req_ready_idle", int'(o_req_ready), 1);
        req_valid = 1'b1;
        wren      = wr;
        data      = d;
        address   = a;
        @(negedge clk);
        req_valid = 1'b0;
        wren      = 1'($urandom);
        data      = 3'($urandom);
        address   = 5'($urandom);
        cyc = 1; busy = 1'b0; nops = 0; done = 1'b0; lat = 0;
        r_maddr0 = 0;
        r_hit = 1'b0; r_wb = 1'b0; r_dirty = 1'b0; r_tag = 0; r_data = 0;
        while (!done && cyc < 60) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end
            if (busy) chk("mem_req_held", int'(o_mem_req), 1);
            if (o_mem_req && !busy) begin
                if (nops == 0) r_maddr0 = int'(o_mem_addr);
                if (e_wb && nops == 0) begin
                    chk("wb_mem_we", int'(o_mem_we), 1);
                    chk("wb_mem_addr", int'(o_mem_addr), e_wba);
                    chk("wb_mem_wdata", int'(o_mem_wdata), e_wbd);
                end else begin
                    chk("refill_mem_we", int'(o_mem_we), 0);
                    chk("refill_mem_addr", int'(o_mem_addr), int'(a));
                end
                nops++;
                busy = 1'b1;
                lat  = $urandom_range(0, 3);
            end
            if (busy && !mem_ack) begin
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    if (o_mem_we) begin
                        backing[int'(o_mem_addr)] = int'(o_mem_wdata);
                        mem_rdata = 3'($urandom);
                    end else begin
                        mem_rdata = 3'(backing[int'(o_mem_addr)]);
                    end
                end else begin
                    lat--;
                end
            end
            if (o_resp_valid) begin
                done    = 1'b1;
                r_hit   = o_hit;
                r_wb    = o_wb;
                r_dirty = o_dirty;
                r_tag   = int'(o_tag);
                r_data  = int'(o_data);
                chk("resp_valid_bit", int'(o_valid), 1);
                chk("resp_mem_req_low", int'(o_mem_req), 0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            chk("resp_timeout", 0, 1);
        end else begin
            chk("model_hit", int'(r_hit), int'(e_hit));
            chk("model_writeback", int'(r_wb), int'(e_wb));
            chk("model_dirty", int'(r_dirty), int'(e_dty));
            chk("model_tag", r_tag, tg);
            chk("model_data", r_data, e_dat);
            chk("model_mem_ops", nops, e_hit ? 0 : (e_wb ? 2 : 1));
            if (e_hit) chk("hit_latency", cyc, 2);
        end
        r_nops = nops;
        @(negedge clk);
        chk("resp_one_cycle", int'(o_resp_valid), 0);
        chk("req_ready_after", int'(o_req_ready), 1);
        mem_ack = ($urandom_range(0, 7) == 0);
    endtask

    typedef struct {
        bit       wr;
        bit [2:0] d;
        bit [4:0] a;
        bit       hit;
        bit       wb;
        bit       dirty;
        int       tag;
        int       dat;
        int       nops;
        int       maddr;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit r_hit, r_wb, r_dirty;
        int r_tag, r_data, r_maddr0, r_nops, cyc;

        vt[0] = '{wr:0, d:0, a:5'b10000, hit:0, wb:0, dirty:0, tag:4, dat:3, nops:1, maddr:16};
        vt[1] = '{wr:0, d:0, a:5'b10000, hit:1, wb:0, dirty:0, tag:4, dat:3, nops:0, maddr:0};
        vt[2] = '{wr:1, d:5, a:5'b00001, hit:0, wb:0, dirty:1, tag:0, dat:5, nops:1, maddr:1};
        vt[3] = '{wr:0, d:0, a:5'b00001, hit:1, wb:0, dirty:1, tag:0, dat:5, nops:0, maddr:0};
        vt[4] = '{wr:1, d:4, a:5'b01001, hit:0, wb:0, dirty:1, tag:2, dat:4, nops:1, maddr:9};
        vt[5] = '{wr:0, d:0, a:5'b00101, hit:0, wb:1, dirty:0, tag:1, dat:2, nops:2, maddr:1};

        for (int i = 0; i < 32; i++) backing[i] = int'($urandom_range(0, 7));
        backing[16] = 3;
        backing[1]  = 0;
        backing[9]  = 6;
        backing[5]  = 2;
        for (int i = 0; i < 32; i++) m_mem[i] = backing[i];
        model_reset();

        sel = 1'b0; req_valid = 1'b0; wren = 1'b0; data = '0; address = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready2", int'(bus2.req_ready), 1);
        chk("rst_req_ready4", int'(bus4.req_ready), 1);
        chk("rst_resp_valid", int'(bus2.resp_valid), 0);
        chk("rst_hit", int'(bus2.hit), 0);
        chk("rst_valid", int'(bus2.valid), 0);
        chk("rst_dirty", int'(bus2.dirty), 0);
        chk("rst_writeback", int'(bus2.writeBack), 0);
        chk("rst_tag", int'(bus2.tag), 0);
        chk("rst_data", int'(bus2.dadoParaCPU), 0);
        chk("rst_mem_req2", int'(bus2.mem_req), 0);
        chk("rst_mem_req4", int'(bus4.mem_req), 0);
        chk("rst_mem_addr", int'(bus2.mem_addr), 0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_req(vt[i].wr, 3'(vt[i].d), 5'(vt[i].a), r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
            chk($sformatf("vec%0d_hit", i), int'(r_hit), int'(vt[i].hit));
            chk($sformatf("vec%0d_wb", i), int'(r_wb), int'(vt[i].wb));
            chk($sformatf("vec%0d_dirty", i), int'(r_dirty), int'(vt[i].dirty));
            chk($sformatf("vec%0d_tag", i), r_tag, vt[i].tag);
            chk($sformatf("vec%0d_data", i), r_data, vt[i].dat);
            chk($sformatf("vec%0d_nops", i), r_nops, vt[i].nops);
            if (vt[i].nops > 0) chk($sformatf("vec%0d_maddr", i), r_maddr0, vt[i].maddr);
        end

`ifdef MEMORIA_CACHE_STATS_EN
        chk("stats_hit_count", int'(hc2), 2);
        chk("stats_miss_count", int'(mc2), 4);
        chk("stats_wb_count", int'(wc2), 1);
`endif

        // Reset while a refill is outstanding: the request is abandoned.
        @(negedge clk);
        mem_ack   = 1'b0;
        req_valid = 1'b1;
        wren      = 1'b0;
        address   = 5'b11110;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!o_mem_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_mem_req_seen", int'(o_mem_req), 1);
        chk("abort_refill_we", int'(o_mem_we), 0);
        resetn = 1'b0;
        #1;
        chk("abort_mem_req_drop", int'(o_mem_req), 0);
        chk("abort_req_ready", int'(o_req_ready), 1);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", int'(o_resp_valid), 0);
        end
        do_req(1'b0, 3'd0, 5'b10000, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        chk("abort_then_miss", int'(r_hit), 0);
        chk("abort_then_refill_addr", r_maddr0, 16);

        // 4-way: five tags in set 0, oldest (dirty) line is evicted.
        sel = 1'b1;
        do_req(1'b1, 3'd7, 5'b00000, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        do_req(1'b0, 3'd0, 5'b00100, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        do_req(1'b0, 3'd0, 5'b01000, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        do_req(1'b0, 3'd0, 5'b01100, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        chk("w4_fourth_miss", int'(r_hit), 0);
        do_req(1'b0, 3'd0, 5'b10000, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        chk("w4_evict_wb", int'(r_wb), 1);
        chk("w4_evict_addr", r_maddr0, 0);
        do_req(1'b0, 3'd0, 5'b00100, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        chk("w4_tag1_hit", int'(r_hit), 1);
        do_req(1'b0, 3'd0, 5'b00000, r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
        chk("w4_tag0_miss", int'(r_hit), 0);
        chk("w4_tag0_clean_evict", int'(r_wb), 0);
        chk("w4_tag0_data", r_data, 7);

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int n = 0; n < 250; n++) begin
                do_req(1'($urandom), 3'($urandom), 5'($urandom),
                       r_hit, r_wb, r_dirty, r_tag, r_data, r_maddr0, r_nops);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "global timeout");
    end
endmodule
